// File: rtl/coincidence_cycle_ctrl_pkg.sv
// Shared constants and state encoding for the coincidence measurement-cycle controller.
// The drain time is derived from the datapath delay taps so the two stay in step.
package coincidence_cycle_ctrl_pkg;

    localparam int DEF_COUNT_W = 13;
    localparam int DEF_TIME_W  = 24;
    localparam int DEF_NCYC_W  = 16;
    localparam int DEF_CLR_CYC = 2;

    // Predelay, short and long coincidence delay taps, plus one settle cycle.
    localparam int TAP_PRE       = 8;
    localparam int TAP_SHORT     = 128;
    localparam int TAP_LONG      = 1024;
    localparam int DRAIN_SETTLE  = 1;
    localparam int DEF_DRAIN_CYC = TAP_PRE + TAP_SHORT + TAP_LONG + DRAIN_SETTLE;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_GATE    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_REPORT  = 3'd5,
        ST_ABORT   = 3'd6
    } state_t;

endpackage

// File: rtl/coincidence_cycle_ctrl_cycle_timer.sv
// Down-counter shared by the timed phases: load N-1 on phase entry, the phase
// ends on the cycle the zero flag is seen, giving exactly N cycles in the phase.
module coincidence_cycle_ctrl_cycle_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == '0);

endmodule

// File: rtl/coincidence_cycle_ctrl.sv
// Measurement-cycle sequencer for the neutron coincidence counter: clear, gate,
// drain, capture and report each cycle; all outputs are registered Moore decodes.
module coincidence_cycle_ctrl
    import coincidence_cycle_ctrl_pkg::*;
#(
    parameter int COUNT_W   = DEF_COUNT_W,
    parameter int TIME_W    = DEF_TIME_W,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC,
    parameter int CLR_CYC   = DEF_CLR_CYC,
    parameter int NCYC_W    = DEF_NCYC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [TIME_W-1:0]  i_gate_len,
    input  logic [NCYC_W-1:0]  i_num_cycles,
    input  logic               i_pulse,
    output logic               o_pulse_gated,
    output logic               o_dp_reset,
    input  logic [COUNT_W-1:0] i_dp_ra,
    input  logic [COUNT_W-1:0] i_dp_a,
    input  logic [COUNT_W-1:0] i_dp_tot,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [COUNT_W-1:0] o_res_ra,
    output logic [COUNT_W-1:0] o_res_a,
    output logic [COUNT_W-1:0] o_res_tot,
    output logic [NCYC_W-1:0]  o_res_idx,
    output logic               o_res_ovf,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [2:0]         o_dbg_state
);

    // Result port: a transfer happens on a clock edge where o_res_valid and
    // i_res_ready are both high; while valid is high the data is held constant
    // and valid only drops on a transfer or an abort.

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   gate_len_q, gate_len_d;
    logic [NCYC_W-1:0]   num_cyc_q, num_cyc_d;
    logic [NCYC_W-1:0]   idx_q, idx_d;
    logic [COUNT_W:0]    pcnt_q, pcnt_d;

    logic                pulse_gated_q, pulse_gated_d;
    logic                dp_reset_q, dp_reset_d;
    logic                res_valid_q, res_valid_d;
    logic [COUNT_W-1:0]  res_ra_q, res_ra_d;
    logic [COUNT_W-1:0]  res_a_q, res_a_d;
    logic [COUNT_W-1:0]  res_tot_q, res_tot_d;
    logic [NCYC_W-1:0]   res_idx_q, res_idx_d;
    logic                res_ovf_q, res_ovf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                tmr_load;
    logic [TIME_W-1:0]   tmr_val;
    logic                tmr_dec;
    logic                tmr_zero;
    logic                abort_hit;
    logic                gate_open;

    coincidence_cycle_ctrl_cycle_timer #(
        .W (TIME_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .i_dec      (tmr_dec),
        .o_zero     (tmr_zero)
    );

    assign abort_hit = i_abort && (state_q != ST_IDLE) && (state_q != ST_ABORT);
    assign gate_open = (state_q == ST_GATE) && !i_abort;
    assign tmr_dec   = (state_q == ST_CLEAR) || (state_q == ST_GATE) ||
                       (state_q == ST_DRAIN) || (state_q == ST_ABORT);

    always_comb begin
        state_d    = state_q;
        gate_len_d = gate_len_q;
        num_cyc_d  = num_cyc_q;
        idx_d      = idx_q;
        pcnt_d     = pcnt_q;
        res_ra_d   = res_ra_q;
        res_a_d    = res_a_q;
        res_tot_d  = res_tot_q;
        res_idx_d  = res_idx_q;
        res_ovf_d  = res_ovf_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        if (abort_hit) begin
            state_d  = ST_ABORT;
            tmr_load = 1'b1;
            tmr_val  = TIME_W'(CLR_CYC - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        if ((i_gate_len == '0) || (i_num_cycles == '0)) begin
                            err_d = 1'b1;
                        end else begin
                            gate_len_d = i_gate_len;
                            num_cyc_d  = i_num_cycles;
                            idx_d      = '0;
                            state_d    = ST_CLEAR;
                            tmr_load   = 1'b1;
                            tmr_val    = TIME_W'(CLR_CYC - 1);
                        end
                    end
                end
                ST_CLEAR: begin
                    pcnt_d = '0;
                    if (tmr_zero) begin
                        state_d  = ST_GATE;
                        tmr_load = 1'b1;
                        tmr_val  = gate_len_q - TIME_W'(1);
                    end
                end
                ST_GATE: begin
                    // Saturate one bit above the datapath width so overflow cannot alias back.
                    if (i_pulse && (pcnt_q != '1)) begin
                        pcnt_d = pcnt_q + (COUNT_W+1)'(1);
                    end
                    if (tmr_zero) begin
                        state_d  = ST_DRAIN;
                        tmr_load = 1'b1;
                        tmr_val  = TIME_W'(DRAIN_CYC - 1);
                    end
                end
                ST_DRAIN: begin
                    if (tmr_zero) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    res_ra_d  = i_dp_ra;
                    res_a_d   = i_dp_a;
                    res_tot_d = i_dp_tot;
                    res_idx_d = idx_q;
                    res_ovf_d = pcnt_q[COUNT_W];
                    state_d   = ST_REPORT;
                end
                ST_REPORT: begin
                    if (i_res_ready) begin
                        if (idx_q == (num_cyc_q - NCYC_W'(1))) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            idx_d    = idx_q + NCYC_W'(1);
                            state_d  = ST_CLEAR;
                            tmr_load = 1'b1;
                            tmr_val  = TIME_W'(CLR_CYC - 1);
                        end
                    end
                end
                ST_ABORT: begin
                    if (tmr_zero) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        pulse_gated_d = i_pulse && gate_open;
        dp_reset_d    = (state_d == ST_CLEAR) || (state_d == ST_ABORT);
        res_valid_d   = (state_d == ST_REPORT);
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            gate_len_q    <= '0;
            num_cyc_q     <= '0;
            idx_q         <= '0;
            pcnt_q        <= '0;
            pulse_gated_q <= 1'b0;
            dp_reset_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_ra_q      <= '0;
            res_a_q       <= '0;
            res_tot_q     <= '0;
            res_idx_q     <= '0;
            res_ovf_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            gate_len_q    <= gate_len_d;
            num_cyc_q     <= num_cyc_d;
            idx_q         <= idx_d;
            pcnt_q        <= pcnt_d;
            pulse_gated_q <= pulse_gated_d;
            dp_reset_q    <= dp_reset_d;
            res_valid_q   <= res_valid_d;
            res_ra_q      <= res_ra_d;
            res_a_q       <= res_a_d;
            res_tot_q     <= res_tot_d;
            res_idx_q     <= res_idx_d;
            res_ovf_q     <= res_ovf_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign o_pulse_gated = pulse_gated_q;
    assign o_dp_reset    = dp_reset_q;
    assign o_res_valid   = res_valid_q;
    assign o_res_ra      = res_ra_q;
    assign o_res_a       = res_a_q;
    assign o_res_tot     = res_tot_q;
    assign o_res_idx     = res_idx_q;
    assign o_res_ovf     = res_ovf_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_err         = err_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_coincidence_cycle_ctrl.sv
// Bench for coincidence_cycle_ctrl: a counting datapath stand-in plus a cycle-phase
// reference model that predicts every control output and each captured result.
module tb_coincidence_cycle_ctrl;

    localparam int CLR   = 2;
    localparam int DRAIN = 8 + 128 + 1024 + 1;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic        i_abort;
    logic [23:0] i_gate_len;
    logic [15:0] i_num_cycles;
    logic        i_pulse;
    logic        o_pulse_gated;
    logic        o_dp_reset;
    logic [12:0] dp_cnt;
    logic [12:0] i_dp_ra;
    logic [12:0] i_dp_a;
    logic [12:0] i_dp_tot;
    logic        o_res_valid;
    logic        i_res_ready;
    logic [12:0] o_res_ra;
    logic [12:0] o_res_a;
    logic [12:0] o_res_tot;
    logic [15:0] o_res_idx;
    logic        o_res_ovf;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [2:0]  o_dbg_state;

    int n_vec;
    int n_err;

    coincidence_cycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_gate_len    (i_gate_len),
        .i_num_cycles  (i_num_cycles),
        .i_pulse       (i_pulse),
        .o_pulse_gated (o_pulse_gated),
        .o_dp_reset    (o_dp_reset),
        .i_dp_ra       (i_dp_ra),
        .i_dp_a        (i_dp_a),
        .i_dp_tot      (i_dp_tot),
        .o_res_valid   (o_res_valid),
        .i_res_ready   (i_res_ready),
        .o_res_ra      (o_res_ra),
        .o_res_a       (o_res_a),
        .o_res_tot     (o_res_tot),
        .o_res_idx     (o_res_idx),
        .o_res_ovf     (o_res_ovf),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_dbg_state   (o_dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: total counter of gated pulses, R+A and A as fixed multiples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_cnt <= '0;
        end else if (o_dp_reset) begin
            dp_cnt <= '0;
        end else if (o_pulse_gated) begin
            dp_cnt <= dp_cnt + 13'd1;
        end
    end
    assign i_dp_tot = dp_cnt;
    assign i_dp_ra  = 13'(dp_cnt * 13'd5);
    assign i_dp_a   = 13'(dp_cnt * 13'd3);

    function automatic logic [5:0] ctl_now();
        return {o_busy, o_dp_reset, o_pulse_gated, o_res_valid, o_done, o_err};
    endfunction

    task automatic test_reset();
        logic [61:0] got;
        got = {ctl_now(), o_res_ra, o_res_a, o_res_tot, o_res_idx, o_res_ovf};
        n_vec++;
        if (got !== 62'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %h exp 0", got);
        end
    endtask

    // Runs n measurement cycles; pulse mode 0 none, 1 random, 2 every cycle,
    // 3 first/last gate cycle plus first cycle after the gate. abort_t > 0 aborts
    // the first cycle at that phase cycle.
    task automatic test_measure(input int g, input int n, input int mode, input int lag,
                                input int abort_t);
        int          pc;
        int          waited;
        bit          p;
        bit          in_win;
        bit          prev_fwd;
        bit          exp_valid;
        logic [5:0]  exp_ctl;
        logic [55:0] exp_dat;
        logic [55:0] got_dat;

        i_gate_len   = g[23:0];
        i_num_cycles = n[15:0];
        i_start      = 1'b1;
        i_abort      = 1'b0;
        i_pulse      = 1'b0;
        i_res_ready  = 1'b0;
        @(posedge clk); #1;
        i_start      = 1'b0;
        i_gate_len   = 24'($urandom);
        i_num_cycles = 16'($urandom);
        prev_fwd     = 1'b0;

        for (int c = 0; c < n; c++) begin
            pc     = 0;
            waited = 0;
            for (int t = 1; t < 20000; t++) begin
                exp_valid = (t >= g + 4 + DRAIN);
                exp_ctl   = {1'b1, (t <= CLR), prev_fwd, exp_valid, 1'b0, 1'b0};
                n_vec++;
                if (ctl_now() !== exp_ctl) begin
                    n_err++;
                    $display("FAIL ctl cyc=%0d t=%0d got %b exp %b", c, t, ctl_now(), exp_ctl);
                end

                if (abort_t != 0 && t == abort_t) begin
                    i_abort     = 1'b1;
                    i_start     = 1'b1;
                    i_pulse     = 1'b0;
                    i_res_ready = 1'b0;
                    @(posedge clk); #1;
                    i_abort = 1'b0;
                    i_start = 1'b0;
                    for (int k = 1; k <= CLR + 2; k++) begin
                        exp_ctl = (k <= CLR) ? 6'b110000 : 6'b000000;
                        n_vec++;
                        if (ctl_now() !== exp_ctl) begin
                            n_err++;
                            $display("FAIL abort_ctl k=%0d got %b exp %b", k, ctl_now(), exp_ctl);
                        end
                        @(posedge clk); #1;
                    end
                    return;
                end

                i_res_ready = 1'b0;
                if (exp_valid) begin
                    exp_dat = {13'(pc * 5), 13'(pc * 3), 13'(pc), 16'(c), (pc > 8191)};
                    got_dat = {o_res_ra, o_res_a, o_res_tot, o_res_idx, o_res_ovf};
                    n_vec++;
                    if (got_dat !== exp_dat) begin
                        n_err++;
                        $display("FAIL result cyc=%0d t=%0d got %h exp %h", c, t, got_dat, exp_dat);
                    end
                    if (waited >= lag) i_res_ready = 1'b1;
                    else waited++;
                end

                case (mode)
                    1:       p = ($urandom_range(0, 3) == 0);
                    2:       p = 1'b1;
                    3:       p = (t == CLR + 1) || (t == CLR + g) || (t == CLR + g + 1);
                    default: p = 1'b0;
                endcase
                in_win   = (t >= CLR + 1) && (t <= CLR + g);
                i_pulse  = p;
                prev_fwd = p && in_win;
                if (p && in_win) pc++;
                i_start  = (mode == 1) && ($urandom_range(0, 7) == 0);

                @(posedge clk); #1;
                if (i_res_ready) break;
            end
            i_res_ready = 1'b0;
            i_pulse     = 1'b0;
            i_start     = 1'b0;
            prev_fwd    = 1'b0;
        end

        n_vec++;
        if (ctl_now() !== 6'b000010) begin
            n_err++;
            $display("FAIL done_pulse got %b exp %b", ctl_now(), 6'b000010);
        end
        @(posedge clk); #1;
        n_vec++;
        if (ctl_now() !== 6'b000000) begin
            n_err++;
            $display("FAIL after_done got %b exp %b", ctl_now(), 6'b000000);
        end
    endtask

    // Rejected starts and requests that must be ignored while idle.
    task automatic test_idle_requests();
        logic [5:0] exp_ctl;
        for (int i = 0; i < 4; i++) begin
            i_gate_len   = (i == 0) ? 24'd0 : 24'd5;
            i_num_cycles = (i == 1) ? 16'd0 : 16'd1;
            i_start      = (i != 3);
            i_abort      = (i >= 2);
            @(posedge clk); #1;
            i_start = 1'b0;
            i_abort = 1'b0;
            exp_ctl = (i < 2) ? 6'b000001 : 6'b000000;
            n_vec++;
            if (ctl_now() !== exp_ctl) begin
                n_err++;
                $display("FAIL idle_req%0d got %b exp %b", i, ctl_now(), exp_ctl);
            end
            @(posedge clk); #1;
            n_vec++;
            if (ctl_now() !== 6'b000000) begin
                n_err++;
                $display("FAIL idle_req%0d_after got %b exp %b", i, ctl_now(), 6'b000000);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [61:0] got;
        i_gate_len   = 24'd10;
        i_num_cycles = 16'd1;
        i_start      = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (10 + 3 + 100) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        got = {ctl_now(), o_res_ra, o_res_a, o_res_tot, o_res_idx, o_res_ovf};
        n_vec++;
        if (got !== 62'd0) begin
            n_err++;
            $display("FAIL async_reset got %h exp 0", got);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            test_measure($urandom_range(1, 200), $urandom_range(1, 2), 1,
                         $urandom_range(0, 5), 0);
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b1;
        i_start      = 1'b0;
        i_abort      = 1'b0;
        i_gate_len   = '0;
        i_num_cycles = '0;
        i_pulse      = 1'b0;
        i_res_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;

        test_measure(100, 1, 0, 0, 0);
        test_measure(50, 1, 3, 0, 0);
        test_measure(20, 3, 1, 20, 0);
        test_measure(9000, 1, 2, 0, 0);
        test_measure(40, 2, 1, 10, CLR + 20);
        test_measure(40, 2, 1, 10, 40 + 4 + DRAIN + 3);
        test_measure(1, 2, 2, 1, 0);
        test_idle_requests();
        test_random();
        test_async_reset();
        test_measure(5, 1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
